// File: rtl/spi_dac_pkg.sv
// spi_dac_pkg: shared definitions for the SPI DAC-control receiver.
//   - receiver FSM state encoding
//   - default frame length, shift register and bit counter widths
//   - bit positions of the fields inside a received frame
//   - saturating increment used by the bit counter
package spi_dac_pkg;

  localparam int FRAME_BITS = 16;
  localparam int SR_W       = 16;
  localparam int CNT_W      = 5;

  // Field positions inside the 16-bit frame (MSB is received first).
  localparam int CH_BIT   = 15;
  localparam int GA_BIT   = 13;
  localparam int SHDN_BIT = 12;
  localparam int LVL_MSB  = 11;
  localparam int LVL_LSB  = 4;
  localparam int LVL_W    = LVL_MSB - LVL_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Counter sticks at all-ones so overlong frames cannot wrap back to a
  // count that looks well-formed.
  function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-flop synchronizer for one asynchronous input, followed by
// a registered copy used for edge detection.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   async_i    : asynchronous input
//   sync_o     : synchronized level
//   rise_o     : one-cycle pulse, synchronized level went 0 -> 1
//   fall_o     : one-cycle pulse, synchronized level went 1 -> 0
// Reset loads IDLE_VAL into every flop so no edge is reported out of reset.
module spi_sync #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= {STAGES{IDLE_VAL}};
      prev_q  <= IDLE_VAL;
    end else begin
      chain_q[0] <= async_i;
      for (int i = 1; i < STAGES; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
      prev_q <= chain_q[STAGES-1];
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = chain_q[STAGES-1] & ~prev_q;
  assign fall_o = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_dac_rx.sv
// spi_dac_rx: receives 16-bit DAC control frames over a write-only SPI link
// (sclk/cs_n/sdata, all asynchronous to clk), checks the bit count and
// publishes the decoded fields plus a per-channel copy of the level.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   spi_sclk     : SPI clock, data sampled on its rising edge
//   spi_cs_n     : active-low frame enable
//   spi_sdata    : serial data, MSB first
//   frame_valid  : one-cycle pulse, frame had exactly FRAME_BITS bits
//   frame_err    : one-cycle pulse, frame had any other bit count
//   rx_channel, rx_gain, rx_shdn_n, rx_level : fields of last valid frame
//   level_ch1/2  : last valid level written to each channel
//   dbg_state_o  : current receiver state (state_e encoding)
// Handshake: there is no backpressure. frame_valid/frame_err are single-cycle
// strobes; rx_* and level_ch* are updated in the same cycle as frame_valid
// and are stable at all other times.
module spi_dac_rx
  import spi_dac_pkg::*;
#(
  parameter int FRAME_BITS  = spi_dac_pkg::FRAME_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi_sclk,
  input  logic             spi_cs_n,
  input  logic             spi_sdata,
  output logic             frame_valid,
  output logic             frame_err,
  output logic             rx_channel,
  output logic             rx_gain,
  output logic             rx_shdn_n,
  output logic [LVL_W-1:0] rx_level,
  output logic [LVL_W-1:0] level_ch1,
  output logic [LVL_W-1:0] level_ch2,
  output logic [1:0]       dbg_state_o
);

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

  // ---------------------------------------------------------------------
  // Input synchronization
  // ---------------------------------------------------------------------
  logic sclk_rise;
  logic sclk_sync_unused;
  logic sclk_fall_unused;
  logic cs_sync;
  logic cs_rise;
  logic cs_fall;

  spi_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sclk (
    .clk    (clk),
    .reset  (reset),
    .async_i(spi_sclk),
    .sync_o (sclk_sync_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall_unused)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_cs (
    .clk    (clk),
    .reset  (reset),
    .async_i(spi_cs_n),
    .sync_o (cs_sync),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // sdata runs through the same depth as sclk so the synchronized data bit
  // lines up with the synchronized sclk rising edge.
  logic [SYNC_STAGES-1:0] sd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sd_q <= '0;
    end else begin
      sd_q[0] <= spi_sdata;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sd_q[i] <= sd_q[i-1];
      end
    end
  end

  logic sd_sync;
  assign sd_sync = sd_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Start qualification
  // ---------------------------------------------------------------------
  // Out of reset the cs_n chain holds a forced '1' that was never sampled.
  // If cs_n is really low (reset in the middle of a frame) that forced '1'
  // would produce a fake falling edge and restart reception mid-frame.
  // prime_q marks when the chain and its edge register hold real samples;
  // armed_q then requires a genuinely observed high level before any
  // falling edge may open a frame.
  logic [SYNC_STAGES:0] prime_q;
  logic                 armed_q;
  logic                 primed;

  assign primed = prime_q[SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      prime_q <= '0;
      armed_q <= 1'b0;
    end else begin
      prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
      if (primed && cs_sync) begin
        armed_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------
  state_e             state_q;
  logic [SR_W-1:0]    sr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               pend_q;
  logic [SR_W-1:0]    sr_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               start_ok;

  // A bit arriving in the same cycle as the closing cs_n edge is folded in
  // here, so the frame check below sees it.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (sclk_rise) begin
      sr_d  = {sr_q[SR_W-2:0], sd_sync};
      cnt_d = cnt_inc_sat(cnt_q);
    end
  end

  // pend_q carries a cs_n falling edge that was seen while in DONE.
  assign start_ok = armed_q && (cs_fall || pend_q);

  // ---------------------------------------------------------------------
  // Receiver FSM with registered outputs
  // ---------------------------------------------------------------------
  logic             frame_valid_q;
  logic             frame_err_q;
  logic             rx_channel_q;
  logic             rx_gain_q;
  logic             rx_shdn_n_q;
  logic [LVL_W-1:0] rx_level_q;
  logic [LVL_W-1:0] level_ch1_q;
  logic [LVL_W-1:0] level_ch2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      sr_q          <= '0;
      cnt_q         <= '0;
      pend_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      rx_channel_q  <= 1'b0;
      rx_gain_q     <= 1'b0;
      rx_shdn_n_q   <= 1'b0;
      rx_level_q    <= '0;
      level_ch1_q   <= '0;
      level_ch2_q   <= '0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_q <= ST_SHIFT;
            sr_q    <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
          end
        end

        ST_SHIFT: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_d;
          if (cs_rise) begin
            state_q <= ST_DONE;
            if (cnt_d == FRAME_CNT) begin
              frame_valid_q <= 1'b1;
              rx_channel_q  <= sr_d[CH_BIT];
              rx_gain_q     <= sr_d[GA_BIT];
              rx_shdn_n_q   <= sr_d[SHDN_BIT];
              rx_level_q    <= sr_d[LVL_MSB:LVL_LSB];
              if (sr_d[CH_BIT]) begin
                level_ch2_q <= sr_d[LVL_MSB:LVL_LSB];
              end else begin
                level_ch1_q <= sr_d[LVL_MSB:LVL_LSB];
              end
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          if (cs_fall && armed_q) begin
            pend_q <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign rx_channel  = rx_channel_q;
  assign rx_gain     = rx_gain_q;
  assign rx_shdn_n   = rx_shdn_n_q;
  assign rx_level    = rx_level_q;
  assign level_ch1   = level_ch1_q;
  assign level_ch2   = level_ch2_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_dac_rx.sv
// Bench for spi_dac_rx: directed SPI frames, a frame-level reference model
// fed through an expected queue, and a per-cycle compare process.
module tb_spi_dac_rx;
  import spi_dac_pkg::*;

  localparam int SYNC_STAGES = 2;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sclk;
  logic       spi_cs_n;
  logic       spi_sdata;
  logic       frame_valid;
  logic       frame_err;
  logic       rx_channel;
  logic       rx_gain;
  logic       rx_shdn_n;
  logic [7:0] rx_level;
  logic [7:0] level_ch1;
  logic [7:0] level_ch2;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_dac_rx #(.FRAME_BITS(16), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk        (clk),
    .reset      (reset),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_sdata  (spi_sdata),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .rx_channel (rx_channel),
    .rx_gain    (rx_gain),
    .rx_shdn_n  (rx_shdn_n),
    .rx_level   (rx_level),
    .level_ch1  (level_ch1),
    .level_ch2  (level_ch2),
    .dbg_state_o(dbg_state)
  );

  // ---------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;

  // Entry: {is_valid, frame word, cycle at which the pulse must be seen}
  logic [48:0] exp_q[$];

  // Model of the published outputs after the last good frame.
  logic       m_ch, m_gain, m_shdn;
  logic [7:0] m_lvl, m_l1, m_l2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ch = 0; m_gain = 0; m_shdn = 0; m_lvl = 0; m_l1 = 0; m_l2 = 0;
    exp_q.delete();
  endtask

  // A frame of exactly 16 bits is good; anything else is an error. The pulse
  // appears after the cs_n edge crosses the synchronizer plus one cycle.
  task automatic push_exp(input logic [31:0] data, input int nbits);
    logic [31:0] due;
    due = cyc + SYNC_STAGES + 1;
    exp_q.push_back({(nbits == 16), data[15:0], due});
  endtask

  // ---------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------
  always @(negedge clk) begin
    logic [48:0] e;
    logic [15:0] w;
    if (!reset) begin
      checks++;
      if (frame_valid && frame_err) begin
        errors++;
        $display("FAIL pulse_exclusive got valid=1 err=1 expected at most one");
      end
      if (frame_valid || frame_err) begin
        if (frame_valid) n_valid++;
        if (frame_err)   n_err++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse got valid=%0b err=%0b expected none (cycle %0d)",
                   frame_valid, frame_err, cyc);
        end else begin
          e = exp_q.pop_front();
          w = e[47:32];
          chk("pulse_kind_valid", {31'd0, frame_valid}, {31'd0, e[48]});
          chk("pulse_cycle", cyc, e[31:0]);
          if (e[48]) begin
            m_ch   = w[15];
            m_gain = w[13];
            m_shdn = w[12];
            m_lvl  = w[11:4];
            if (w[15]) m_l2 = w[11:4];
            else       m_l1 = w[11:4];
          end
        end
      end
      chk("rx_channel", {31'd0, rx_channel}, {31'd0, m_ch});
      chk("rx_gain",    {31'd0, rx_gain},    {31'd0, m_gain});
      chk("rx_shdn_n",  {31'd0, rx_shdn_n},  {31'd0, m_shdn});
      chk("rx_level",   {24'd0, rx_level},   {24'd0, m_lvl});
      chk("level_ch1",  {24'd0, level_ch1},  {24'd0, m_l1});
      chk("level_ch2",  {24'd0, level_ch2},  {24'd0, m_l2});
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks (all called at a falling clk edge)
  // ---------------------------------------------------------------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift data[nbits-1:0] MSB first; sclk high and low each last 'half'
  // clk cycles. With 'close' set, cs_n rises together with the last sclk
  // rising edge.
  task automatic send_bits(input logic [31:0] data, input int nbits, input int half,
                           input bit close);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_sdata = data[i];
      wait_clk(half);
      spi_sclk = 1'b1;
      if (close && i == 0) begin
        spi_cs_n = 1'b1;
        push_exp(data, nbits);
      end
      wait_clk(half);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] data, input int nbits, input int half,
                            input bit coincide);
    spi_cs_n = 1'b0;
    wait_clk(half);
    send_bits(data, nbits, half, coincide);
    if (!coincide) begin
      wait_clk(half);
      spi_cs_n = 1'b1;
      push_exp(data, nbits);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      wait_clk(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending frames expected 0", exp_q.size());
      exp_q.delete();
    end
    wait_clk(4);
  endtask

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  logic [15:0] b2b[6];
  int v0, e0;

  initial begin
    b2b[0] = 16'h1110; b2b[1] = 16'h9220; b2b[2] = 16'h3C30;
    b2b[3] = 16'hB440; b2b[4] = 16'h0550; b2b[5] = 16'hD660;

    reset = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_sdata = 1'b0;
    model_reset();
    wait_clk(4);
    chk("reset_valid", {31'd0, frame_valid}, 32'd0);
    chk("reset_err",   {31'd0, frame_err},   32'd0);
    chk("reset_level", {24'd0, rx_level},    32'd0);
    chk("reset_ch1",   {24'd0, level_ch1},   32'd0);
    chk("reset_ch2",   {24'd0, level_ch2},   32'd0);
    chk("reset_state", {30'd0, dbg_state},   {30'd0, ST_IDLE});
    reset = 1'b0;
    wait_clk(10);

    // sclk activity with cs_n high must produce nothing.
    for (int i = 0; i < 3; i++) begin
      spi_sclk = 1'b1; wait_clk(4); spi_sclk = 1'b0; wait_clk(4);
    end

    // Single frame to channel 1, sclk period 8 clk.
    send_frame(32'h1A50, 16, 4, 1'b0);
    drain();
    chk("t1_rx_level", {24'd0, rx_level}, 32'hA5);
    chk("t1_ch1",      {24'd0, level_ch1}, 32'hA5);
    chk("t1_ch2",      {24'd0, level_ch2}, 32'h00);
    chk("t1_shdn",     {31'd0, rx_shdn_n}, 32'd1);
    chk("t1_nvalid",   n_valid, 32'd1);

    // Channel 2 then channel 1.
    send_frame(32'h9FF0, 16, 4, 1'b0);
    drain();
    chk("t2a_ch2",  {24'd0, level_ch2}, 32'hFF);
    chk("t2a_chan", {31'd0, rx_channel}, 32'd1);
    send_frame(32'h1010, 16, 4, 1'b0);
    drain();
    chk("t2b_ch1",  {24'd0, level_ch1}, 32'h01);
    chk("t2b_ch2",  {24'd0, level_ch2}, 32'hFF);
    chk("t2b_chan", {31'd0, rx_channel}, 32'd0);

    // Short and long frames.
    v0 = n_valid; e0 = n_err;
    send_frame(32'h5A5A, 15, 4, 1'b0);
    wait_clk(3);
    send_frame(32'h1FFF0, 17, 4, 1'b0);
    drain();
    chk("t3_nerr",   n_err - e0, 32'd2);
    chk("t3_nvalid", n_valid - v0, 32'd0);
    chk("t3_ch1",    {24'd0, level_ch1}, 32'h01);
    chk("t3_ch2",    {24'd0, level_ch2}, 32'hFF);

    // Last sclk rise coincident with cs_n rise.
    send_frame(32'h1330, 16, 4, 1'b1);
    drain();
    chk("t4_rx_level", {24'd0, rx_level}, 32'h33);

    // Reset after 8 bits with cs_n still low; then a clean frame.
    v0 = n_valid; e0 = n_err;
    spi_cs_n = 1'b0;
    wait_clk(4);
    send_bits(32'h1F, 8, 4, 1'b0);
    wait_clk(2);
    reset = 1'b1;
    model_reset();
    wait_clk(3);
    reset = 1'b0;
    wait_clk(12);
    spi_cs_n = 1'b1;
    wait_clk(12);
    chk("t5_no_pulse", (n_valid - v0) + (n_err - e0), 32'd0);
    send_frame(32'h1120, 16, 4, 1'b0);
    drain();
    chk("t5_rx_level", {24'd0, rx_level}, 32'h12);
    chk("t5_ch1",      {24'd0, level_ch1}, 32'h12);
    chk("t5_ch2",      {24'd0, level_ch2}, 32'h00);

    // Back-to-back frames, cs_n high 2 clk, sclk period 6 clk.
    v0 = n_valid;
    for (int i = 0; i < 6; i++) begin
      send_frame({16'd0, b2b[i]}, 16, 3, 1'b0);
      wait_clk(2);
    end
    drain();
    chk("t6_nvalid", n_valid - v0, 32'd6);
    chk("t6_ch1",    {24'd0, level_ch1}, 32'h55);
    chk("t6_ch2",    {24'd0, level_ch2}, 32'h66);
    chk("t6_chan",   {31'd0, rx_channel}, 32'd1);
    chk("t6_gain",   {31'd0, rx_gain}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the sequence is a few thousand cycles long.
  initial begin
    #400000;
    $display("FAIL watchdog got timeout expected sequence end");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
